// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: NREQ requesters share one FIFO write port, with bursts of up to
// MAXBURST words per grant and one arbitration cycle between bursts.
module fifo_wr_arb #(
  parameter int DSIZE    = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                       wclk,
  input  logic                       wrst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*DSIZE-1:0]      req_data,
  input  logic [NREQ-1:0]            req_last,
  output logic [NREQ-1:0]            gnt,
  output logic [DSIZE-1:0]           fifo_wdata,
  output logic                       fifo_winc,
  input  logic                       fifo_wfull,
  output logic                       busy,
  output logic [$clog2(NREQ)-1:0]    owner
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAXBURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [OW-1:0] rr, rr_nxt, owner_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [OW:0]   sel;
  logic          beat;
  logic          burst_end;

  // Returns {found, index} of the first set bit at or above start, wrapping past NREQ-1.
  function automatic logic [OW:0] pick(input logic [NREQ-1:0] r, input logic [OW-1:0] start);
    logic [OW:0] res;
    int          idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NREQ;
      if (r[idx]) res = {1'b1, OW'(idx)};
    end
    return res;
  endfunction

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state <= IDLE;
      rr    <= '0;
      owner <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
      owner <= owner_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr;
    owner_nxt  = owner;
    count_nxt  = count;
    beat       = 1'b0;
    burst_end  = 1'b0;
    gnt        = '0;
    fifo_winc  = 1'b0;
    fifo_wdata = '0;
    sel        = pick(req, rr);
    case (state)
      IDLE: begin
        if (sel[OW]) begin
          owner_nxt = sel[OW-1:0];
          count_nxt = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        beat = req[owner] && !fifo_wfull;
        if (!req[owner]) begin
          burst_end = 1'b1;
        end else if (beat) begin
          count_nxt = count + CW'(1);
          if (req_last[owner] || count_nxt == CW'(MAXBURST)) burst_end = 1'b1;
        end
        if (burst_end) begin
          state_nxt = IDLE;
          rr_nxt    = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);
        end
        // Outputs are also masked while reset is asserted so nothing escapes in the reset cycle.
        if (beat && wrst_n) begin
          fifo_winc  = 1'b1;
          gnt[owner] = 1'b1;
          fifo_wdata = req_data[int'(owner)*DSIZE +: DSIZE];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios plus random traffic, compared each cycle against a
// transaction-level round-robin model.
module tb_fifo_wr_arb;

  localparam int DSIZE    = 8;
  localparam int NREQ     = 4;
  localparam int MAXBURST = 4;
  localparam int OW       = 2;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req, req_last, gnt;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [DSIZE-1:0]      fifo_wdata;
  logic                  fifo_winc, fifo_wfull, busy;
  logic [OW-1:0]         owner;

  int checks = 0;
  int errors = 0;

  // Model: whether a burst is in progress, who owns it, words written so far, next search start.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_rr    = 0;
  int m_cnt   = 0;

  always #5 wclk = ~wclk;

  fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .req_last(req_last),
    .gnt(gnt), .fifo_wdata(fifo_wdata), .fifo_winc(fifo_winc), .fifo_wfull(fifo_wfull),
    .busy(busy), .owner(owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_beat();
    return m_busy && req[m_owner] && !fifo_wfull;
  endfunction

  task automatic sample();
    bit          w;
    logic [31:0] eg, ed;
    @(negedge wclk);
    w  = model_beat() && wrst_n;
    eg = w ? (32'd1 << m_owner) : 32'd0;
    ed = w ? 32'(req_data[m_owner*DSIZE +: DSIZE]) : 32'd0;
    chk("winc",  32'(fifo_winc), 32'(w));
    chk("gnt",   32'(gnt), eg);
    chk("wdata", 32'(fifo_wdata), ed);
    chk("busy",  32'(busy), 32'(m_busy));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    chk("winc_while_full", 32'(fifo_winc & fifo_wfull), 32'd0);
  endtask

  task automatic advance();
    bit b, fin;
    @(posedge wclk);
    b   = model_beat();
    fin = 1'b0;
    if (!wrst_n) begin
      m_busy = 0; m_rr = 0; m_owner = 0; m_cnt = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!m_busy && req[(m_rr + k) % NREQ]) begin
          m_owner = (m_rr + k) % NREQ;
          m_cnt   = 0;
          m_busy  = 1;
        end
      end
    end else begin
      if (!req[m_owner]) fin = 1;
      else if (b) begin
        m_cnt++;
        if (req_last[m_owner] || m_cnt == MAXBURST) fin = 1;
      end
      if (fin) begin
        m_busy = 0;
        m_rr   = (m_owner + 1) % NREQ;
      end
    end
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  initial begin
    wrst_n = 1'b0; req = '0; req_last = '0; req_data = '0; fifo_wfull = 1'b0;
    cycle(); cycle();

    // Single-word packet from requester 0
    wrst_n = 1'b1; req = 4'b0001; req_last = 4'b0001; req_data = 32'h0000_00A5;
    sample(); chk("arb_no_write", 32'(fifo_winc), 32'd0); advance();
    sample();
    chk("first_winc", 32'(fifo_winc), 32'd1);
    chk("first_wdata", 32'(fifo_wdata), 32'hA5);
    chk("first_gnt", 32'(gnt), 32'b0001);
    advance();
    req = '0; req_last = '0;
    sample(); chk("back_idle", 32'(busy), 32'd0); advance();

    // All requesters hold req with no packet ends: full-length round-robin bursts
    req = 4'b1111;
    for (int i = 0; i < 26; i++) begin
      req_data = $urandom;
      cycle();
    end
    req = '0;
    cycle(); cycle();

    // Requester 2 stalled by a full FIFO for three cycles mid-burst
    wrst_n = 1'b0; cycle(); wrst_n = 1'b1;
    req = 4'b0100; req_data = 32'h00C3_0000;
    cycle(); cycle();
    fifo_wfull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("stall_winc", 32'(fifo_winc), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_owner", 32'(owner), 32'd2);
      advance();
    end
    fifo_wfull = 1'b0;
    sample(); chk("resume_winc", 32'(fifo_winc), 32'd1); advance();
    cycle(); cycle();
    req = '0;
    cycle();

    // Requester 1 abandons its burst after two words; next search starts at 2
    wrst_n = 1'b0; cycle(); wrst_n = 1'b1;
    req = 4'b0010; req_data = 32'h0000_5A00;
    cycle(); cycle(); cycle();
    req = '0;
    cycle();
    req = 4'b0101; req_data = 32'h0011_0022;
    cycle();
    sample(); chk("rr_after_drop", 32'(owner), 32'd2); advance();
    req = '0;
    cycle(); cycle();

    // Reset during the second word of a burst; pointer returns to 0
    req = 4'b1000; req_data = 32'h7700_0000;
    cycle(); cycle();
    wrst_n = 1'b0;
    sample(); chk("reset_mid_winc", 32'(fifo_winc), 32'd0); advance();
    wrst_n = 1'b1; req = 4'b1001; req_data = 32'h7700_0011;
    sample(); chk("after_reset_busy", 32'(busy), 32'd0); advance();
    sample(); chk("after_reset_owner", 32'(owner), 32'd0); advance();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req        = 4'($urandom);
      req_last   = 4'($urandom) & 4'($urandom);
      req_data   = $urandom;
      fifo_wfull = ($urandom_range(0, 3) == 0);
      wrst_n     = ($urandom_range(0, 49) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DSIZE, default 8, sets the data word width and SHALL match the FIFO DSIZE.
REQ-002 Parameter NREQ, default 4, sets the number of requesters (2..8).
REQ-003 Parameter MAXBURST, default 4, sets the maximum words per grant (1..16).
REQ-004 Port wclk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port wrst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port req, input, NREQ bits: requester i has a word pending when bit i is 1.
REQ-007 Port req_data, input, NREQ*DSIZE bits: requester i word at bits [i*DSIZE +: DSIZE].
REQ-008 Port req_last, input, NREQ bits: the pending word of requester i ends its packet.
REQ-009 Port gnt, output, NREQ bits: one-hot accept strobe; the word of requester i is consumed in a cycle where bit i is 1.
REQ-010 Port fifo_wdata, output, DSIZE bits: write data to the FIFO write port.
REQ-011 Port fifo_winc, output, 1 bit: write strobe to the FIFO write port.
REQ-012 Port fifo_wfull, input, 1 bit: full flag from the FIFO write domain.
REQ-013 Port busy, output, 1 bit: 1 while in GRANT.
REQ-014 Port owner, output, $clog2(NREQ) bits: index of the current or most recent grantee.

Function
REQ-015 The FSM SHALL have two states: IDLE and GRANT.
REQ-016 IDLE: if req is nonzero, select the first set bit searching upward from pointer rr with wrap; latch it into owner, clear beat count, go to GRANT; no write in this cycle.
REQ-017 GRANT: beat = req[owner] AND NOT fifo_wfull; fifo_winc = beat; gnt = beat ? (1<<owner) : 0; fifo_wdata = slice of owner; all are combinational from registered state.
REQ-018 fifo_winc SHALL never be 1 in a cycle where fifo_wfull is 1.
REQ-019 gnt SHALL be zero in IDLE and in any GRANT cycle without a beat, and at most one bit SHALL be set.
REQ-020 Beat counter SHALL be $clog2(MAXBURST+1) bits wide and increment on each beat.
REQ-021 The burst SHALL end, returning to IDLE next cycle, on a beat with req_last[owner]=1, or on the beat that makes count equal MAXBURST, or in any GRANT cycle with req[owner]=0.
REQ-022 At burst end, rr SHALL be set to owner+1 modulo NREQ.
REQ-023 While fifo_wfull=1 in GRANT, the FSM SHALL hold state, owner and count.
REQ-024 Requests from non-owners SHALL be ignored during GRANT; no preemption.
REQ-025 Latency SHALL be one cycle from IDLE with req to the first possible fifo_winc.
REQ-026 Sustained throughput SHALL be one word per cycle within a burst, plus one idle arbitration cycle between bursts.
REQ-027 fifo_wdata SHALL be 0 whenever fifo_winc is 0.

Reset
REQ-028 When wrst_n=0 at a rising edge: state=IDLE, rr=0, owner=0, count=0.
REQ-029 During and after reset until arbitration: gnt=0, fifo_winc=0, fifo_wdata=0, busy=0.
REQ-030 Reset asserted mid-burst SHALL abort the burst with no further fifo_winc and no gnt from the next cycle onward.

Verification
REQ-031 Reset, then req=0001, req_last[0]=1, data0=0xA5 -> GRANT in cycle 1; in cycle 2 fifo_winc=1, fifo_wdata=0xA5, gnt=0001; then IDLE, rr=1.
REQ-032 req=1111 held, req_last=0, MAXBURST=4 -> four-beat bursts in owner order 0,1,2,3,0; gnt never multi-hot; one idle cycle between bursts.
REQ-033 Owner 2 in GRANT, fifo_wfull=1 for 3 cycles mid-burst -> fifo_winc=0 and gnt=0 for those 3 cycles; count held; burst resumes after.
REQ-034 Owner 1 drops req after 2 beats -> IDLE next cycle; rr=2; req[0] and req[2] both set -> requester 2 is granted.
REQ-035 wrst_n=0 during the 2nd beat of a burst -> no fifo_winc after reset; busy=0; next grant searches from requester 0.
